// File: rtl/serial_tx.sv
// serial_tx: framed parallel-to-serial transmitter (start, data LSB first, stop).
// Ports: clk, reset (async active-low), tx_valid/tx_data/tx_ready handshake, tx_out line, busy.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_out_q, tx_out_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              last_cyc;

  assign last_cyc = (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_out_q <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_out_q <= tx_out_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      IDLE: begin
        if (tx_valid && ready_q) begin
          shift_d = tx_data;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (last_cyc) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (last_cyc) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_MAX) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (last_cyc) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the next state.
  // In DATA the line carries bit 0 of the next shift value.
  always_comb begin
    tx_out_d = 1'b1;
    ready_d  = 1'b0;
    busy_d   = 1'b1;
    unique case (state_d)
      IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      START:   tx_out_d = 1'b0;
      DATA:    tx_out_d = shift_d[0];
      STOP:    tx_out_d = 1'b1;
      default: tx_out_d = 1'b1;
    endcase
  end

  assign tx_out   = tx_out_q;
  assign tx_ready = ready_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: random and directed stimulus against a frame-level model.
// Two instances: defaults (8 bits, 4 clocks/bit) and corner (4 bits, 1 clock/bit).
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       va = 1'b0, vb = 1'b0;
  logic [7:0] da = '0;
  logic [3:0] db = '0;
  logic       ra, oa, ba, rb, ob, bb;

  int tests = 0;
  int fails = 0;

  int         rem_a = 0, rem_b = 0;
  logic [7:0] word_a = '0, word_b = '0;
  logic       sa_out, sa_rdy, sb_out, sb_rdy;

  localparam int FA = 40;
  localparam int FB = 6;

  always #5 clk = ~clk;

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) u_a (
    .clk(clk), .reset(rst_n), .tx_valid(va), .tx_data(da),
    .tx_ready(ra), .tx_out(oa), .busy(ba)
  );

  serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) u_b (
    .clk(clk), .reset(rst_n), .tx_valid(vb), .tx_data(db),
    .tx_ready(rb), .tx_out(ob), .busy(bb)
  );

  function automatic logic fbit(input logic [7:0] w, input int p,
                                input int cpb, input int dw);
    int idx;
    idx = p / cpb;
    if (idx == 0) return 1'b0;
    if (idx <= dw) return w[idx-1];
    return 1'b1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: compare at negedge, advance model at posedge, resume at +2.
  task automatic tick();
    logic eb;
    @(negedge clk);
    eb = (rem_a > 0);
    check("a_busy", int'(ba), int'(eb));
    check("a_ready", int'(ra), int'(!eb));
    check("a_out", int'(oa), int'(eb ? fbit(word_a, FA - rem_a, 4, 8) : 1'b1));
    eb = (rem_b > 0);
    check("b_busy", int'(bb), int'(eb));
    check("b_ready", int'(rb), int'(!eb));
    check("b_out", int'(ob), int'(eb ? fbit(word_b, FB - rem_b, 1, 4) : 1'b1));
    sa_out = oa; sa_rdy = ra; sb_out = ob; sb_rdy = rb;
    @(posedge clk);
    if (!rst_n) begin
      rem_a = 0;
      rem_b = 0;
    end else begin
      if (rem_a == 0 && va) begin
        rem_a = FA; word_a = da;
      end else if (rem_a > 0) rem_a--;
      if (rem_b == 0 && vb) begin
        rem_b = FB; word_b = {4'b0, db};
      end else if (rem_b > 0) rem_b--;
    end
    #2;
  endtask

  task automatic wait_ready(input bit sel);
    int g;
    g = 0;
    while (!(sel ? rb : ra) && g < 200) begin
      tick();
      g++;
    end
    check("ready_timeout", int'(sel ? rb : ra), 1);
  endtask

  // Send one word and record the line and ready for 60 cycles after accept.
  task automatic send(input bit sel, input logic [7:0] d,
                      output logic [59:0] line, output int lat);
    wait_ready(sel);
    if (sel) begin vb = 1'b1; db = d[3:0]; end
    else     begin va = 1'b1; da = d; end
    tick();
    if (sel) begin vb = 1'b0; db = ~d[3:0]; end
    else     begin va = 1'b0; da = ~d; end
    lat = -1;
    for (int k = 0; k < 60; k++) begin
      tick();
      line[k] = sel ? sb_out : sa_out;
      if (lat < 0 && (sel ? sb_rdy : sa_rdy)) lat = k;
    end
  endtask

  task automatic check_frame_a(input string name, input logic [59:0] line,
                               input logic [9:0] exp);
    logic [9:0] got;
    for (int j = 0; j < 10; j++) got[j] = line[j*4 + 1];
    check(name, int'(got), int'(exp));
  endtask

  initial begin
    logic [59:0] line;
    int          lat;
    int          idle_cnt;
    logic [59:0] line2;
    logic [29:0] rdy2;

    rst_n = 1'b0;
    tick(); tick();
    check("rst_out", int'(oa), 1);
    check("rst_ready", int'(ra), 1);
    check("rst_busy", int'(ba), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    // A5: start, 1,0,1,0,0,1,0,1, stop (index 0 = start bit).
    send(1'b0, 8'hA5, line, lat);
    check_frame_a("frame_a5", line, 10'b11010_01010);
    check("lat_a5", lat, 40);
    check("hold_a5", int'({line[4], line[5], line[6], line[7]}), 4'hF);

    // 3C with tx_data flipped to C3 right after acceptance.
    send(1'b0, 8'h3C, line, lat);
    check_frame_a("frame_3c", line, 10'b10011_11000);

    // Back-to-back: 00 held, FF offered as soon as the first is taken.
    wait_ready(1'b0);
    va = 1'b1; da = 8'h00;
    tick();
    da = 8'hFF;
    idle_cnt = 0;
    for (int k = 0; k < 81; k++) begin
      tick();
      if (sa_rdy) idle_cnt++;
      if (k < 60) line2[k] = sa_out;
      if (k >= 40 && k < 70) rdy2[k-40] = sa_rdy;
      if (k == 40) va = 1'b0;
    end
    check("b2b_idle", idle_cnt, 1);
    check("b2b_gap_pos", int'(rdy2[1:0]), 1);
    check("b2b_d0", int'(line2[5]), 0);
    check("b2b_start2", int'(line2[41]), 0);
    check("b2b_d1", int'(line2[46]), 1);
    for (int i = 0; i < 45; i++) tick();

    // Mid-frame async reset during the data bits.
    wait_ready(1'b0);
    va = 1'b1; da = 8'h81;
    tick();
    va = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    check("pre_rst_busy", int'(ba), 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_out", int'(oa), 1);
    check("mid_rst_busy", int'(ba), 0);
    check("mid_rst_ready", int'(ra), 1);
    rem_a = 0; rem_b = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    send(1'b0, 8'h01, line, lat);
    check_frame_a("frame_01", line, 10'b10000_00010);
    check("lat_01", lat, 40);

    // Corner instance: 1010 -> 0,0,1,0,1,1.
    send(1'b1, 8'h0A, line, lat);
    check("frame_b", int'(line[5:0]), int'(6'b110100));
    check("lat_b", lat, 6);

    // Randomized traffic on both instances.
    for (int i = 0; i < 4000; i++) begin
      va = ($urandom_range(0, 3) == 0);
      da = 8'($urandom);
      vb = ($urandom_range(0, 2) == 0);
      db = 4'($urandom);
      if ($urandom_range(0, 999) == 0) begin
        #1 rst_n = 1'b0;
        #1;
        check("rnd_rst_out", int'(oa & ob), 1);
        rem_a = 0; rem_b = 0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    va = 1'b0; vb = 1'b0;
    for (int i = 0; i < 50; i++) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
Parallel-to-serial framed transmitter built around a shift register. It accepts a DATA_W-bit word over a valid/ready handshake and drives it onto a single-bit line as a frame: start bit, data LSB first, stop bit. It is the sending end of the single-wire serial link that the lab's flip-flop/shift-register capture blocks sample bit by bit.

Parameters:
DATA_W, 8, width of the parallel data word (>= 1).
CLKS_PER_BIT, 4, clock cycles each serial bit is held (>= 1).

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
tx_valid  input  1  producer has a word on tx_data.
tx_data  input  DATA_W  word to transmit; sampled only at acceptance.
tx_ready  output  1  transmitter can accept a word this cycle.
tx_out  output  1  serial line; idles high.
busy  output  1  frame in progress (start, data or stop bit being driven).

Behaviour:
- Reset (reset=0, asynchronous):
  - Values: tx_out=1, tx_ready=1, busy=0, state=IDLE, bit/cycle counters=0, shift register=0.
  - No word is accepted while reset=0.
  - Mid-frame reset aborts the frame immediately; line returns high without waiting for a clock edge.
- States: IDLE, START, DATA, STOP. All outputs are registered.
- IDLE:
  - tx_ready=1, busy=0, tx_out=1.
  - Accept on a rising edge with tx_valid=1 and tx_ready=1: latch tx_data into the shift register, go to START.
  - From the next cycle: tx_out=0, tx_ready=0, busy=1.
- START: tx_out=0 for exactly CLKS_PER_BIT cycles, then DATA.
- DATA:
  - Each bit is held CLKS_PER_BIT cycles, LSB first.
  - Shift right after each bit; bit counter runs 0..DATA_W-1; after the last bit go to STOP.
- STOP:
  - tx_out=1 for exactly CLKS_PER_BIT cycles, then IDLE.
  - tx_ready rises in the first cycle after the stop bit ends.
- Frame timing:
  - Total frame length is (DATA_W+2)*CLKS_PER_BIT cycles from the cycle after acceptance; 40 cycles at defaults.
  - Back-to-back: if tx_valid=1 in the first IDLE cycle, the word is accepted there and the next start bit begins the cycle after. Minimum gap between frames is 1 idle-high cycle.
- Data stability: changes on tx_data or tx_valid after acceptance have no effect on the current frame.
- tx_valid held high while busy: ignored, no accept. The word is accepted when tx_ready returns high.
- tx_valid is not required to stay high; a deasserted request is simply never taken.
- Counters:
  - Cycle counter width is max(1, $clog2(CLKS_PER_BIT)); it wraps to 0 at CLKS_PER_BIT-1.
  - With CLKS_PER_BIT=1, each bit lasts exactly one cycle.
- Invariant: busy == !tx_ready at all times outside reset.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release, tx_valid=0 for 10 cycles -> tx_out=1, tx_ready=1, busy=0 throughout.
- Single frame at defaults: send tx_data=8'hA5 -> after acceptance, the line carries 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop). Each bit is held 4 cycles; tx_ready returns high 40 cycles after acceptance.
- Back-to-back: tx_valid held high with 8'h00, then 8'h FF offered on the same cycle tx_ready rises -> two 40-cycle frames with exactly one idle-high cycle between them. Data bits are all 0, then all 1.
- Data change mid-frame: accept 8'h3C, change tx_data to 8'hC3 one cycle later -> serialized bits match 8'h3C (0,0,1,1,1,1,0,0).
- Reset mid-frame: start 8'h81, assert reset during the DATA state between clock edges -> tx_out=1 and busy=0 immediately. After release, the next accepted word 8'h01 transmits a clean full frame.
- Parameter corner: DATA_W=4, CLKS_PER_BIT=1, send 4'b1010 -> tx_out sequence 0,0,1,0,1,1 on consecutive cycles, and tx_ready returns high 6 cycles after acceptance.
